// File: rtl/resize_frame_ctrl_if.sv
// Pixel stream bundle between the upstream source, this controller and the resizer.
// There is no backpressure: a beat is any cycle with valid high, and sof/eof/payload are ignored otherwise.
interface resize_frame_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] in_payload_i;
    logic                  in_valid_i;
    logic                  in_sof_i;
    logic                  in_eof_i;
    logic [DATA_WIDTH-1:0] out_payload_o;
    logic                  out_valid_o;
    logic                  out_sof_o;
    logic                  out_eof_o;

    modport slave (
        input  in_payload_i, in_valid_i, in_sof_i, in_eof_i,
        output out_payload_o, out_valid_o, out_sof_o, out_eof_o
    );
    modport master (
        output in_payload_i, in_valid_i, in_sof_i, in_eof_i,
        input  out_payload_o, out_valid_o, out_sof_o, out_eof_o
    );
endinterface

// File: rtl/resize_frame_ctrl.sv
// Frame gate in front of the resizer: admits whole frames, shadows the resize
// configuration until a frame start, and checks each frame's length.
module resize_frame_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_WIDTH  = 4800,
    parameter int MAX_HEIGHT = 4800,
    parameter int MAX_FACTOR = 8,
    parameter int DEF_WIDTH  = 400,
    parameter int DEF_HEIGHT = 400,
    parameter int DEF_FACTOR = 2,
    localparam int WW = $clog2(MAX_WIDTH + 1),
    localparam int WH = $clog2(MAX_HEIGHT + 1),
    localparam int WF = $clog2(MAX_FACTOR + 1)
) (
    input  logic          clk,
    input  logic          rst_i,
    input  logic          enable_i,
    input  logic          cfg_write_i,
    input  logic [WW-1:0] cfg_width_i,
    input  logic [WH-1:0] cfg_height_i,
    input  logic [WF-1:0] cfg_factor_i,
    resize_frame_ctrl_if.slave bus,
    output logic [WW-1:0] act_width_o,
    output logic [WH-1:0] act_height_o,
    output logic [WF-1:0] act_factor_o,
    output logic          cfg_err_o,
    output logic          len_err_o,
    output logic          frame_done_o,
    output logic          busy_o,
    output logic [15:0]   frame_cnt_o,
    output logic [15:0]   drop_cnt_o,
    output logic [15:0]   err_cnt_o,
    output logic [1:0]    state_o
);
    localparam logic [WW-1:0] W_MAX = WW'(MAX_WIDTH);
    localparam logic [WH-1:0] H_MAX = WH'(MAX_HEIGHT);
    localparam logic [WF-1:0] F_MAX = WF'(MAX_FACTOR);
    localparam logic [WW-1:0] W_ONE = WW'(1);
    localparam logic [WH-1:0] H_ONE = WH'(1);

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        WAIT_SOF = 2'd1,
        ACTIVE   = 2'd2,
        DISCARD  = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [WW-1:0] x, x_nxt, pos_x, g_w, pend_w;
    logic [WH-1:0] y, y_nxt, pos_y, g_h, pend_h;
    logic [WF-1:0] pend_f;
    logic          pend_dirty;
    logic          sof_b, eof_b, cfg_ok;
    logic          fwd, start, apply, last, end_beat, len_err, drop;

    assign state_o = state;
    assign busy_o  = (state == ACTIVE) || (state == DISCARD);

    always_comb begin
        sof_b     = bus.in_valid_i & bus.in_sof_i;
        eof_b     = bus.in_valid_i & bus.in_eof_i;
        cfg_ok    = cfg_write_i
                    && (cfg_width_i  != '0) && (cfg_width_i  <= W_MAX)
                    && (cfg_height_i != '0) && (cfg_height_i <= H_MAX)
                    && (cfg_factor_i != '0) && (cfg_factor_i <= F_MAX);
        state_nxt = state;
        x_nxt     = x;
        y_nxt     = y;
        fwd       = 1'b0;
        start     = 1'b0;
        len_err   = 1'b0;
        drop      = 1'b0;

        case (state)
            DISABLED: begin
                drop = sof_b;
                if (enable_i) state_nxt = WAIT_SOF;
            end
            WAIT_SOF: begin
                if (!enable_i) begin
                    drop      = sof_b;
                    state_nxt = DISABLED;
                end else if (sof_b) begin
                    fwd   = 1'b1;
                    start = 1'b1;
                end
            end
            ACTIVE: begin
                if (bus.in_valid_i) begin
                    fwd = 1'b1;
                    // An SOF inside a frame restarts the frame on this very beat.
                    if (sof_b) begin
                        start   = 1'b1;
                        len_err = 1'b1;
                    end
                end
            end
            DISCARD: begin
                drop = sof_b;
                if (eof_b) state_nxt = enable_i ? WAIT_SOF : DISABLED;
            end
            default: state_nxt = DISABLED;
        endcase

        // A starting beat is position (0,0) of the geometry it brings in with it.
        apply    = start & pend_dirty;
        g_w      = apply ? pend_w : act_width_o;
        g_h      = apply ? pend_h : act_height_o;
        pos_x    = start ? '0 : x;
        pos_y    = start ? '0 : y;
        last     = (pos_x == g_w - W_ONE) && (pos_y == g_h - H_ONE);
        end_beat = fwd & (eof_b | last);

        if (fwd) begin
            if (eof_b != last) len_err = 1'b1;
            if (eof_b) begin
                state_nxt = enable_i ? WAIT_SOF : DISABLED;
            end else if (last) begin
                state_nxt = DISCARD;
            end else begin
                state_nxt = ACTIVE;
                if (pos_x == g_w - W_ONE) begin
                    x_nxt = '0;
                    y_nxt = pos_y + H_ONE;
                end else begin
                    x_nxt = pos_x + W_ONE;
                    y_nxt = pos_y;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state             <= DISABLED;
            x                 <= '0;
            y                 <= '0;
            bus.out_valid_o   <= 1'b0;
            bus.out_payload_o <= '0;
            bus.out_sof_o     <= 1'b0;
            bus.out_eof_o     <= 1'b0;
            frame_done_o      <= 1'b0;
            len_err_o         <= 1'b0;
            cfg_err_o         <= 1'b0;
            act_width_o       <= WW'(DEF_WIDTH);
            act_height_o      <= WH'(DEF_HEIGHT);
            act_factor_o      <= WF'(DEF_FACTOR);
            pend_w            <= WW'(DEF_WIDTH);
            pend_h            <= WH'(DEF_HEIGHT);
            pend_f            <= WF'(DEF_FACTOR);
            pend_dirty        <= 1'b0;
            frame_cnt_o       <= '0;
            drop_cnt_o        <= '0;
            err_cnt_o         <= '0;
        end else begin
            state             <= state_nxt;
            x                 <= x_nxt;
            y                 <= y_nxt;
            bus.out_valid_o   <= fwd;
            bus.out_payload_o <= fwd ? bus.in_payload_i : '0;
            bus.out_sof_o     <= start;
            bus.out_eof_o     <= end_beat;
            frame_done_o      <= end_beat;
            len_err_o         <= len_err;
            cfg_err_o         <= cfg_write_i & ~cfg_ok;

            if (apply) begin
                act_width_o  <= pend_w;
                act_height_o <= pend_h;
                act_factor_o <= pend_f;
            end
            // A write landing on the applying SOF re-arms dirty for the next frame.
            if (cfg_ok) begin
                pend_w     <= cfg_width_i;
                pend_h     <= cfg_height_i;
                pend_f     <= cfg_factor_i;
                pend_dirty <= 1'b1;
            end else if (apply) begin
                pend_dirty <= 1'b0;
            end

            if (fwd && last && frame_cnt_o != 16'hFFFF) frame_cnt_o <= frame_cnt_o + 16'd1;
            if (drop && drop_cnt_o != 16'hFFFF)         drop_cnt_o  <= drop_cnt_o + 16'd1;
            if (len_err && err_cnt_o != 16'hFFFF)       err_cnt_o   <= err_cnt_o + 16'd1;
        end
    end
endmodule

// File: tb/tb_resize_frame_ctrl.sv
// Bench for resize_frame_ctrl: directed frame scenarios followed by random frames, checked
// each cycle against a beat-index model of the frame rules.
module tb_resize_frame_ctrl;
  localparam int DW = 8;
  localparam int WW = 13;
  localparam int WH = 13;
  localparam int WF = 4;
  localparam int M_OFF = 0, M_ARM = 1, M_IN = 2, M_SKIP = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          cfg_write = 1'b0;
  logic [WW-1:0] cfg_w = '0;
  logic [WH-1:0] cfg_h = '0;
  logic [WF-1:0] cfg_f = '0;
  logic [WW-1:0] act_w;
  logic [WH-1:0] act_h;
  logic [WF-1:0] act_f;
  logic          cfg_err, len_err, frame_done, busy;
  logic [15:0]   frame_cnt, drop_cnt, err_cnt;
  logic [1:0]    state_dbg;

  resize_frame_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  resize_frame_ctrl dut (
    .clk(clk), .rst_i(rst), .enable_i(enable), .cfg_write_i(cfg_write),
    .cfg_width_i(cfg_w), .cfg_height_i(cfg_h), .cfg_factor_i(cfg_f),
    .bus(bus.slave),
    .act_width_o(act_w), .act_height_o(act_h), .act_factor_o(act_f),
    .cfg_err_o(cfg_err), .len_err_o(len_err), .frame_done_o(frame_done), .busy_o(busy),
    .frame_cnt_o(frame_cnt), .drop_cnt_o(drop_cnt), .err_cnt_o(err_cnt), .state_o(state_dbg)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [DW+2:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  int m_mode, m_idx;
  int a_w, a_h, a_f, p_w, p_h, p_f;
  bit p_dirty;
  int n_frame, n_drop, n_lerr;
  logic [2:0] e_pulse;

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic model_step();
    bit sofb, eofb, take, newf, last, lerr, cerr, done;
    logic [DW+2:0] s;
    s = '0; take = 0; newf = 0; lerr = 0; cerr = 0; done = 0;
    if (rst) begin
      m_mode = M_OFF; m_idx = 0;
      a_w = 400; a_h = 400; a_f = 2; p_w = 400; p_h = 400; p_f = 2; p_dirty = 0;
      n_frame = 0; n_drop = 0; n_lerr = 0;
      e_pulse = '0;
      exp_q.push_back('0);
      return;
    end
    sofb = bus.in_valid_i && bus.in_sof_i;
    eofb = bus.in_valid_i && bus.in_eof_i;
    case (m_mode)
      M_OFF: begin
        if (sofb) n_drop = sat(n_drop + 1);
        if (enable) m_mode = M_ARM;
      end
      M_ARM: begin
        if (!enable) begin
          if (sofb) n_drop = sat(n_drop + 1);
          m_mode = M_OFF;
        end else if (sofb) begin
          take = 1; newf = 1;
        end
      end
      M_IN: begin
        if (bus.in_valid_i) begin
          take = 1;
          if (sofb) begin newf = 1; lerr = 1; end
        end
      end
      default: begin
        if (sofb) n_drop = sat(n_drop + 1);
        if (eofb) m_mode = enable ? M_ARM : M_OFF;
      end
    endcase
    if (take) begin
      if (newf) begin
        if (p_dirty) begin a_w = p_w; a_h = p_h; a_f = p_f; p_dirty = 0; end
        m_idx = 0;
      end
      last = (m_idx == a_w * a_h - 1);
      s = {1'b1, newf, eofb || last, bus.in_payload_i};
      if (eofb || last) begin
        done = 1;
        if (last) n_frame = sat(n_frame + 1);
        if (eofb != last) lerr = 1;
        m_mode = eofb ? (enable ? M_ARM : M_OFF) : M_SKIP;
      end else begin
        m_idx++;
        m_mode = M_IN;
      end
    end
    if (lerr) n_lerr = sat(n_lerr + 1);
    if (cfg_write) begin
      if (cfg_w >= 1 && cfg_w <= 4800 && cfg_h >= 1 && cfg_h <= 4800 && cfg_f >= 1 && cfg_f <= 8) begin
        p_w = int'(cfg_w); p_h = int'(cfg_h); p_f = int'(cfg_f); p_dirty = 1;
      end else begin
        cerr = 1;
      end
    end
    e_pulse = {cerr, lerr, done};
    exp_q.push_back(s);
  endtask

  // ---------------- driver ----------------
  task automatic step();
    logic [DW+2:0] e;
    model_step();
    @(posedge clk);
    #1;
    cfg_write = 1'b0;
    e = exp_q.pop_front();
    check("stream", {bus.out_valid_o, bus.out_sof_o, bus.out_eof_o, bus.out_payload_o}, e);
    check("pulses", {cfg_err, len_err, frame_done}, e_pulse);
    check("act", {act_w, act_h, act_f}, {WW'(a_w), WH'(a_h), WF'(a_f)});
    check("frame_cnt", frame_cnt, 16'(n_frame));
    check("drop_cnt", drop_cnt, 16'(n_drop));
    check("err_cnt", err_cnt, 16'(n_lerr));
    check("busy", busy, (m_mode == M_IN || m_mode == M_SKIP));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.in_valid_i   = 1'b0;
      bus.in_sof_i     = 1'($urandom_range(0, 1));
      bus.in_eof_i     = 1'($urandom_range(0, 1));
      bus.in_payload_i = DW'($urandom);
      step();
    end
  endtask

  task automatic beat(input bit s, input bit e);
    bus.in_valid_i   = 1'b1;
    bus.in_sof_i     = s;
    bus.in_eof_i     = e;
    bus.in_payload_i = DW'($urandom);
    step();
  endtask

  task automatic cfg_req(input int w, input int h, input int f);
    cfg_write = 1'b1;
    cfg_w = WW'(w);
    cfg_h = WH'(h);
    cfg_f = WF'(f);
  endtask

  int q_w, q_h, q_f;

  // n beats; sof on beat 0 (and sof_at), eof on eof_at; random gaps of gmin..gmax idles.
  task automatic frame(input int n, input int eof_at, input int sof_at, input int gmin,
                       input int gmax, input int dis_at, input bit mid_cfg);
    for (int i = 0; i < n; i++) begin
      if (mid_cfg && i == 5) cfg_req(q_w, q_h, q_f);
      if (i == dis_at) enable = 1'b0;
      beat(i == 0 || i == sof_at, i == eof_at);
      idle($urandom_range(gmin, gmax));
    end
  endtask

  initial begin
    int n, r;
    bus.in_valid_i = 1'b0; bus.in_sof_i = 1'b0; bus.in_eof_i = 1'b0; bus.in_payload_i = '0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    idle(1);

    // Clean 4x3 frame with 3-cycle gaps.
    cfg_req(4, 3, 1); idle(1);
    enable = 1'b1; idle(2);
    frame(12, 11, -1, 3, 3, -1, 0);

    // Reconfigure mid-frame: current frame stays 4x3, next is 8x2 factor 4.
    q_w = 8; q_h = 2; q_f = 4;
    frame(12, 11, -1, 0, 1, -1, 1);
    frame(16, 15, -1, 0, 1, -1, 0);

    // Rejected writes leave pending and active alone.
    cfg_req(4, 3, 0); idle(1);
    cfg_req(4801, 3, 1); idle(2);
    frame(16, 15, -1, 0, 0, -1, 0);

    // Disable at the midpoint: frame completes, following SOFs are dropped.
    cfg_req(4, 3, 1); idle(1);
    frame(12, 11, -1, 0, 0, -1, 0);
    frame(12, 11, -1, 0, 1, 6, 0);
    frame(12, 11, -1, 0, 1, -1, 0);
    frame(12, 11, -1, 0, 1, -1, 0);
    enable = 1'b1; idle(2);

    // Early EOF, then missing EOF with two trailing beats.
    frame(12, 6, -1, 0, 1, -1, 0);
    frame(14, 13, -1, 0, 1, -1, 0);
    // SOF mid-frame restart, and a single-beat frame that is an early EOF.
    frame(15, 14, 3, 0, 1, -1, 0);
    beat(1, 1); idle(2);

    // Reset at beat 5, then a clean frame after reprogramming.
    for (int i = 0; i < 5; i++) beat(i == 0, 0);
    rst = 1'b1; beat(0, 0); step();
    rst = 1'b0; idle(1);
    cfg_req(4, 3, 1); enable = 1'b1; idle(2);
    frame(12, 11, -1, 0, 1, -1, 0);

    // 1x1 geometry: sof+eof on one beat is a full frame.
    cfg_req(1, 1, 1); idle(1);
    beat(1, 1); idle(1);
    beat(1, 0); idle(2); beat(0, 1); idle(1);

    // Random phase.
    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        cfg_req($urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(0, 9));
        idle(1);
      end else if (r == 2) begin
        enable = ($urandom_range(0, 3) != 0);
        idle($urandom_range(0, 2));
      end else begin
        n = ($urandom_range(0, 1) == 1) ? (p_dirty ? p_w * p_h : a_w * a_h) : $urandom_range(1, 22);
        if (n > 24) n = $urandom_range(1, 22);
        frame(n,
              ($urandom_range(0, 2) != 0) ? n - 1 : $urandom_range(0, n),
              ($urandom_range(0, 7) == 0) ? $urandom_range(1, n) : -1,
              0, 2,
              ($urandom_range(0, 5) == 0) ? $urandom_range(0, n) : -1,
              0);
        if (enable == 1'b0 && $urandom_range(0, 1) == 1) enable = 1'b1;
        idle($urandom_range(0, 3));
      end
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
